// File: rtl/jt1943_rom_pkg.sv
// rtl/jt1943_rom_pkg.sv - shared types and defaults for the ROM arbiter
// Contents:
//   arb_state_t  : arbiter FSM states
//   TOUT_DEFAULT : default data_rdy watchdog limit in cycles
package jt1943_rom_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_DATA = 2'd2
  } arb_state_t;

  localparam int TOUT_DEFAULT = 63;

endpackage

// File: rtl/jt1943_rom_slot.sv
// rtl/jt1943_rom_slot.sv - single-entry ROM cache for one requester
// Ports:
//   clk, rst       : clock, synchronous active-high reset (clears everything)
//   flush          : clears the valid bit only (loop reset / download)
//   cs, addr       : requester strobe and word address
//   wr_en          : store wr_tag/wr_data and mark the entry valid
//   wr_tag/wr_data : tag and word for the write port
//   inval          : clear the valid bit (watchdog abort)
//   ok             : entry is valid and matches the requested address
//   dout           : cached word
module jt1943_rom_slot
  import jt1943_rom_pkg::*;
#(
  parameter int AW = 22
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          wr_en,
  input  logic          inval,
  input  logic [AW-1:0] wr_tag,
  input  logic [31:0]   wr_data,
  output logic          ok,
  output logic [31:0]   dout
);

  logic          valid;
  logic [AW-1:0] tag;

  // Flush outranks a same-cycle write so an aborted transfer never lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      dout  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (wr_en) begin
      valid <= 1'b1;
      tag   <= wr_tag;
      dout  <= wr_data;
    end else if (inval) begin
      valid <= 1'b0;
    end
  end

  // Gated by rst so a stale valid bit cannot leak out during reset.
  assign ok = ~rst & cs & valid & (addr == tag);

endmodule

// File: rtl/jt1943_rom_arb.sv
// rtl/jt1943_rom_arb.sv - fixed-priority ROM cache arbiter in front of an SDRAM controller
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   loop_rst             : frame loop reset, aborts the transfer and flushes the caches
//   downloading          : ROM download active, arbiter held idle and flushed
//   slot_cs/slot_addr    : per-slot request and word address (slot n at [n*AW+:AW])
//   slot_ok/slot_dout    : per-slot hit flag and cached word
//   sdram_req/sdram_addr : request and address towards the SDRAM controller
//   sdram_ack            : controller accepted the request
//   data_rdy/data_read   : returned read word
//   refresh_en           : controller may refresh (idle, nothing pending)
module jt1943_rom_arb
  import jt1943_rom_pkg::*;
#(
  parameter int SLOTS = 5,
  parameter int AW    = 22,
  parameter int TOUT  = TOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              loop_rst,
  input  logic              downloading,
  input  logic [SLOTS-1:0]    slot_cs,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS-1:0]    slot_ok,
  output logic [SLOTS*32-1:0] slot_dout,
  output logic              sdram_req,
  output logic [AW-1:0]     sdram_addr,
  input  logic              sdram_ack,
  input  logic              data_rdy,
  input  logic [31:0]       data_read,
  output logic              refresh_en
);

  localparam int GW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam int WW = $clog2(TOUT + 2);

  arb_state_t       state;
  logic [GW-1:0]    grant;
  logic [WW-1:0]    wdog;
  logic [SLOTS-1:0] pending;
  logic             any_pend;
  logic [GW-1:0]    next_gnt;
  logic [AW-1:0]    next_addr;
  logic             abort;
  logic             wr_hit;
  logic             tout_hit;

  assign pending  = slot_cs & ~slot_ok;
  assign abort    = loop_rst | downloading;
  assign wr_hit   = (state == WAIT_DATA) & data_rdy;
  assign tout_hit = (state == WAIT_DATA) & ~data_rdy & (wdog == WW'(TOUT));

  // Lowest pending index wins; the address mux uses constant indices only.
  always_comb begin
    any_pend  = 1'b0;
    next_gnt  = '0;
    next_addr = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (pending[i] && !any_pend) begin
        any_pend  = 1'b1;
        next_gnt  = GW'(i);
        next_addr = slot_addr[i*AW +: AW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      grant      <= '0;
      wdog       <= '0;
    end else if (abort) begin
      state     <= IDLE;
      sdram_req <= 1'b0;
      wdog      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_pend) begin
            grant      <= next_gnt;
            sdram_addr <= next_addr;
            sdram_req  <= 1'b1;
            state      <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            wdog      <= '0;
            state     <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (data_rdy || tout_hit) begin
            state <= IDLE;
          end else begin
            wdog <= wdog + WW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The write goes under the tag latched at grant time, not the live address.
  for (genvar n = 0; n < SLOTS; n++) begin : g_slot
    jt1943_rom_slot #(.AW(AW)) u_slot (
      .clk     (clk),
      .rst     (rst),
      .flush   (abort),
      .cs      (slot_cs[n]),
      .addr    (slot_addr[n*AW +: AW]),
      .wr_en   (wr_hit & (grant == GW'(n))),
      .inval   (tout_hit & (grant == GW'(n))),
      .wr_tag  (sdram_addr),
      .wr_data (data_read),
      .ok      (slot_ok[n]),
      .dout    (slot_dout[n*32 +: 32])
    );
  end

  assign refresh_en = (state == IDLE) & ~any_pend & ~rst & ~abort;

endmodule

// File: tb/tb_jt1943_rom_arb.sv
// tb/tb_jt1943_rom_arb.sv - scoreboard bench for the ROM cache arbiter
module tb_jt1943_rom_arb;
  localparam int SLOTS = 5;
  localparam int AW    = 22;

  logic                clk = 1'b0;
  logic                rst;
  logic                loop_rst;
  logic                downloading;
  logic [SLOTS-1:0]    slot_cs;
  logic [SLOTS*AW-1:0] slot_addr;
  logic [SLOTS-1:0]    slot_ok;
  logic [SLOTS*32-1:0] slot_dout;
  logic                sdram_req;
  logic [AW-1:0]       sdram_addr;
  logic                sdram_ack;
  logic                data_rdy;
  logic [31:0]         data_read;
  logic                refresh_en;

  jt1943_rom_arb #(.SLOTS(SLOTS), .AW(AW), .TOUT(63)) dut (
    .clk         (clk),
    .rst         (rst),
    .loop_rst    (loop_rst),
    .downloading (downloading),
    .slot_cs     (slot_cs),
    .slot_addr   (slot_addr),
    .slot_ok     (slot_ok),
    .slot_dout   (slot_dout),
    .sdram_req   (sdram_req),
    .sdram_addr  (sdram_addr),
    .sdram_ack   (sdram_ack),
    .data_rdy    (data_rdy),
    .data_read   (data_read),
    .refresh_en  (refresh_en)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [AW-1:0] exp_q[$];
  int rmode = 0;  // 0 off, 1 normal, 2 ack without data, 3 data 20 cycles late

  // Reference cache contents
  logic          mvalid[SLOTS];
  logic [AW-1:0] mtag[SLOTS];
  logic [AW-1:0] cur_addr[SLOTS];

  function automatic logic [31:0] data_of(input logic [AW-1:0] a);
    logic [31:0] x;
    x = {10'b0, a} ^ 32'h0000_1234;
    return 32'hDEADBEEF ^ (x * 32'h9E3779B1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int s, input logic [AW-1:0] a);
    slot_addr[s*AW +: AW] = a;
    cur_addr[s] = a;
  endtask

  function automatic logic [31:0] dout_of(input int s);
    return slot_dout[s*32 +: 32];
  endfunction

  // sel: 0 sdram_ack, 1 data_rdy, 2 refresh_en, 3 sdram_req
  task automatic wait_for(input int sel, input int maxc, input string name);
    int n;
    n = 0;
    checks++;
    forever begin
      @(negedge clk);
      if ((sel == 0 && sdram_ack) || (sel == 1 && data_rdy) ||
          (sel == 2 && refresh_en) || (sel == 3 && sdram_req)) break;
      n++;
      if (n >= maxc) begin
        errors++;
        $display("FAIL timeout_%s: not seen within %0d cycles", name, maxc);
        break;
      end
    end
  endtask

  task automatic clear_model;
    for (int s = 0; s < SLOTS; s++) mvalid[s] = 1'b0;
  endtask

  // SDRAM controller model
  initial begin
    int m;
    logic [AW-1:0] a;
    sdram_ack = 1'b0;
    data_rdy  = 1'b0;
    data_read = '0;
    forever begin
      step;
      if (rmode != 0 && sdram_req && !rst) begin
        m = rmode;
        a = sdram_addr;
        repeat ($urandom_range(0, 3)) step;
        sdram_ack = 1'b1;
        step;
        sdram_ack = 1'b0;
        if (m == 1) repeat ($urandom_range(0, 3)) step;
        else if (m == 3) repeat (20) step;
        if (m != 2) begin
          data_read = data_of(a);
          data_rdy  = 1'b1;
          step;
          data_rdy  = 1'b0;
        end
      end
    end
  end

  // Monitor: every new request must match the next expected address
  logic          req_q = 1'b0;
  logic [AW-1:0] addr_q = '0;
  always @(negedge clk) begin
    if (!rst) begin
      if (sdram_req && !req_q) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got addr %0h expected no request", sdram_addr);
        end else begin
          chk("req_addr", sdram_addr, exp_q.pop_front());
        end
      end else if (sdram_req && req_q) begin
        chk("req_hold", sdram_addr, addr_q);
      end
    end
    req_q  = sdram_req;
    addr_q = sdram_addr;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [SLOTS-1:0] ncs;
    logic [AW-1:0] na;

    rst = 1'b1; loop_rst = 1'b0; downloading = 1'b0;
    slot_cs = '1; slot_addr = '0;
    for (int s = 0; s < SLOTS; s++) begin
      mvalid[s] = 1'b0; mtag[s] = '0; cur_addr[s] = '0;
    end
    repeat (3) step;
    @(negedge clk);
    chk("rst_slot_ok", slot_ok, 0);
    chk("rst_refresh", refresh_en, 0);
    chk("rst_req", sdram_req, 0);
    chk("rst_addr", sdram_addr, 0);
    chk("rst_dout", slot_dout, 0);
    step;
    rst = 1'b0; slot_cs = '0;
    @(negedge clk);
    chk("idle_refresh", refresh_en, 1);
    chk("idle_slot_ok", slot_ok, 0);

    // Miss then hit on slot 2
    step;
    rmode = 1;
    set_addr(2, 22'h1234);
    slot_cs = 5'b00100;
    exp_q.push_back(22'h1234);
    @(negedge clk);
    chk("miss_refresh", refresh_en, 0);
    chk("miss_ok2", slot_ok[2], 0);
    wait_for(1, 50, "t1_data");
    @(negedge clk);
    chk("hit_ok2", slot_ok[2], 1);
    chk("hit_dout2", dout_of(2), 32'hDEADBEEF);
    repeat (8) @(negedge clk);
    chk("hit_no_req", sdram_req, 0);
    chk("hit_refresh", refresh_en, 1);

    // Simultaneous misses on slots 1, 3, 4
    step;
    set_addr(1, 22'h0ABCD); set_addr(3, 22'h1F00F); set_addr(4, 22'h2AAAA);
    slot_cs = 5'b11010;
    exp_q.push_back(22'h0ABCD); exp_q.push_back(22'h1F00F); exp_q.push_back(22'h2AAAA);
    wait_for(2, 300, "t2_done");
    chk("multi_q_empty", exp_q.size(), 0);
    chk("multi_ok", slot_ok, 5'b11010);
    chk("multi_dout1", dout_of(1), data_of(22'h0ABCD));
    chk("multi_dout3", dout_of(3), data_of(22'h1F00F));
    chk("multi_dout4", dout_of(4), data_of(22'h2AAAA));

    // Address change while slot 0 is in flight
    step;
    rmode = 3;
    set_addr(0, 22'h10);
    slot_cs = 5'b00001;
    exp_q.push_back(22'h10);
    wait_for(0, 50, "t3_ack");
    step;
    set_addr(0, 22'h20);
    exp_q.push_back(22'h20);
    wait_for(1, 60, "t3_data");
    step;
    rmode = 1;
    @(negedge clk);
    chk("chg_ok0_stale", slot_ok[0], 0);
    wait_for(2, 100, "t3_done");
    chk("chg_ok0", slot_ok[0], 1);
    chk("chg_dout0", dout_of(0), data_of(22'h20));

    // loop_rst during WAIT_DATA, late data must be dropped
    step;
    rmode = 3;
    set_addr(1, 22'h333);
    slot_cs = 5'b00011;
    exp_q.push_back(22'h333);
    wait_for(0, 50, "t4_ack");
    step; step;
    loop_rst = 1'b1;
    step;
    @(negedge clk);
    chk("lrst_req", sdram_req, 0);
    chk("lrst_ok", slot_ok, 0);
    chk("lrst_refresh", refresh_en, 0);
    step;
    loop_rst = 1'b0;
    slot_cs = '0;
    clear_model();
    repeat (25) @(negedge clk);
    step;
    rmode = 1;
    slot_cs = 5'b00010;
    exp_q.push_back(22'h333);
    @(negedge clk);
    chk("lrst_no_write", slot_ok[1], 0);
    wait_for(2, 100, "t4_done");
    chk("lrst_ok1", slot_ok[1], 1);
    chk("lrst_dout1", dout_of(1), data_of(22'h333));

    // Watchdog: ack without data
    step;
    rmode = 2;
    set_addr(3, 22'h3AB);
    slot_cs = 5'b01000;
    exp_q.push_back(22'h3AB);
    wait_for(0, 50, "t5_ack");
    step;
    rmode = 1;
    exp_q.push_back(22'h3AB);
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (sdram_req) break;
      n++;
    end
    chk("wdog_not_early", (n >= 60), 1);
    chk("wdog_not_late", (n <= 70), 1);
    wait_for(2, 100, "t5_done");
    chk("wdog_ok3", slot_ok[3], 1);
    chk("wdog_dout3", dout_of(3), data_of(22'h3AB));

    // refresh_en and downloading
    @(negedge clk);
    chk("ref_all_hit", refresh_en, 1);
    step;
    slot_cs = '0;
    @(negedge clk);
    chk("ref_no_cs", refresh_en, 1);
    step;
    slot_cs = 5'b01000;
    downloading = 1'b1;
    @(negedge clk);
    chk("dl_refresh", refresh_en, 0);
    step;
    @(negedge clk);
    chk("dl_ok", slot_ok, 0);
    chk("dl_refresh2", refresh_en, 0);
    chk("dl_req", sdram_req, 0);
    step;
    downloading = 1'b0;
    slot_cs = '0;
    clear_model();
    @(negedge clk);
    chk("dl_release_refresh", refresh_en, 1);

    // Randomized rounds against the cache model
    for (int r = 0; r < 30; r++) begin
      step;
      for (int s = 0; s < SLOTS; s++) begin
        ncs[s] = 1'($urandom_range(0, 1));
        if (!mvalid[s] || $urandom_range(0, 2) == 0) na = {s[2:0], 19'($urandom)};
        else na = mtag[s];
        set_addr(s, na);
        if (ncs[s] && !(mvalid[s] && mtag[s] == na)) exp_q.push_back(na);
      end
      slot_cs = ncs;
      wait_for(2, 400, "round");
      chk("rnd_q_empty", exp_q.size(), 0);
      for (int s = 0; s < SLOTS; s++) begin
        if (ncs[s]) begin
          chk("rnd_ok", slot_ok[s], 1);
          chk("rnd_dout", dout_of(s), data_of(cur_addr[s]));
          mvalid[s] = 1'b1;
          mtag[s]   = cur_addr[s];
        end
      end
    end

    repeat (5) @(negedge clk);
    chk("final_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
